// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction constants and the branch target table.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam int INSTR_W = 9;
    localparam logic [INSTR_W-1:0] DONE_INSTR = 9'b010000000;

    localparam int LUT_ENTRIES = 32;
    localparam int LUT_ENTRY_W = 10;
    typedef logic [LUT_ENTRY_W-1:0] lut_entry_t;

    localparam lut_entry_t BRANCH_LUT [LUT_ENTRIES] = '{
        10'd0,   10'd5,   10'd100, 10'd40,  10'd12,  10'd20,  10'd200, 10'd300,
        10'd64,  10'd128, 10'd256, 10'd512, 10'd777, 10'd999, 10'd15,  10'd16,
        10'd33,  10'd66,  10'd99,  10'd132, 10'd165, 10'd198, 10'd231, 10'd264,
        10'd297, 10'd330, 10'd363, 10'd396, 10'd429, 10'd462, 10'd1000, 10'd1022
    };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch target lookup: LUT index to a zero-extended PC_W target.
module branch_lut #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 5
) (
    input  logic [LUT_IDX_W-1:0] idx_i,
    output logic [PC_W-1:0]      target_o
);
    import cpu_pkg::*;

    assign target_o = PC_W'(BRANCH_LUT[idx_i]);

endmodule

// File: rtl/fetch_unit.sv
// PC register and instruction fetch stage with start/done handshake.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_IDX_W = 5,
    parameter int START_PC  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               branch_en_i,
    input  logic               branch_taken_i,
    input  logic               done_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic               done_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        cycle_cnt_o,
    output logic [15:0]        instr_cnt_o
`endif
);
    import cpu_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] branch_target;
    logic            start_accept;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .idx_i    (instr_i[LUT_IDX_W-1:0]),
        .target_o (branch_target)
    );

    // start only matters while not executing; in RUN it is ignored
    assign start_accept = start && (state_q == IDLE || state_q == HALT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, HALT: begin
                if (start_accept) begin
                    state_d = RUN;
                    pc_d    = PC_W'(START_PC);
                end
            end
            RUN: begin
                if (stall_i) begin
                    pc_d = pc_q;
                end else if (done_i) begin
                    state_d = HALT;
                end else if (branch_en_i && branch_taken_i) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of ordering.
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o          = pc_q;
    assign instr_valid_o = (state_q == RUN);
    assign instr_o       = instr_valid_o ? instr_i : '0;
    assign done_o        = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic        retire;

    // the done instruction retires too; only a stall withholds retirement
    assign retire = (state_q == RUN) && !stall_i;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (start_accept) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            if (state_q == RUN && cycle_cnt_q != 16'hFFFF) cycle_cnt_d = cycle_cnt_q + 16'd1;
            if (retire && instr_cnt_q != 16'hFFFF)         instr_cnt_d = instr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`endif

endmodule
